// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute/memory/write-back handshake, bus and RAM read signals of the memory stage
interface mem_stage_if;
  logic [79:0] EXE_to_MEM_bus;
  logic        EXE_to_MEM_valid;
  logic        MEM_allow_in;
  logic [31:0] data_ram_r_data;
  logic        WB_allow_in;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic [39:0] MEM_to_BY_bus;

  modport master (
    output EXE_to_MEM_bus, EXE_to_MEM_valid, data_ram_r_data, WB_allow_in,
    input  MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_BY_bus
  );

  modport slave (
    input  EXE_to_MEM_bus, EXE_to_MEM_valid, data_ram_r_data, WB_allow_in,
    output MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_BY_bus
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access pipeline stage: load wait, one-shot read capture, byte align/extend
module mem_stage #(
  parameter int LOAD_WAIT = 0
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave mem
);
  localparam logic [2:0] LW = 3'(LOAD_WAIT);

  logic        mem_valid;
  logic [79:0] bus_r;
  logic [2:0]  wcnt;
  logic [31:0] ld_hold;
  logic        ld_held;

  logic [2:0]  valid_stage;
  logic        rf_w_en;
  logic        sel_load;
  logic [1:0]  sel_wd;
  logic [4:0]  w_addr;
  logic [31:0] alu_result;
  logic [31:0] inst_pc;

  assign valid_stage = bus_r[79:77];
  assign rf_w_en     = bus_r[76];
  assign sel_load    = bus_r[75];
  assign sel_wd      = bus_r[74:73];
  assign w_addr      = bus_r[68:64];
  assign alu_result  = bus_r[63:32];
  assign inst_pc     = bus_r[31:0];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{valid_stage[2], valid_stage[0], bus_r[72:69]};

  logic is_load, wait_done, ready_go, allow_in, accept;

  assign is_load   = mem_valid & sel_load;
  assign wait_done = (wcnt == LW);
  assign ready_go  = is_load ? (ld_held | wait_done) : 1'b1;
  assign allow_in  = ~mem_valid | (ready_go & mem.WB_allow_in);
  assign accept    = mem.EXE_to_MEM_valid & allow_in;

  // A new instruction always restarts the wait/capture sequence, even if the old one captured this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      bus_r     <= '0;
      wcnt      <= '0;
      ld_hold   <= '0;
      ld_held   <= 1'b0;
    end else begin
      if (allow_in)
        mem_valid <= mem.EXE_to_MEM_valid;
      if (accept) begin
        bus_r   <= mem.EXE_to_MEM_bus;
        wcnt    <= '0;
        ld_held <= 1'b0;
      end else if (is_load && !ld_held) begin
        if (wait_done) begin
          ld_hold <= mem.data_ram_r_data;
          ld_held <= 1'b1;
        end else begin
          wcnt <= wcnt + 3'd1;
        end
      end
    end
  end

  logic [31:0] raw;
  logic [7:0]  byte_sel;
  logic [31:0] rf_w_data;
  logic        sel_valid;

  assign raw = ld_held ? ld_hold : mem.data_ram_r_data;

  always_comb begin
    byte_sel = raw[7:0];
    case (alu_result[1:0])
      2'b00: byte_sel = raw[7:0];
      2'b01: byte_sel = raw[15:8];
      2'b10: byte_sel = raw[23:16];
      2'b11: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
  end

  always_comb begin
    rf_w_data = alu_result;
    if (sel_load) begin
      case (sel_wd)
        2'b01:   rf_w_data = {{24{byte_sel[7]}}, byte_sel};
        2'b10:   rf_w_data = {24'b0, byte_sel};
        default: rf_w_data = raw;
      endcase
    end
  end

  assign sel_valid = is_load ? (mem_valid & ready_go) : (mem_valid & valid_stage[1]);

  assign mem.MEM_allow_in    = allow_in;
  assign mem.MEM_to_WB_valid = mem_valid & ready_go;
  assign mem.MEM_to_WB_bus   = {rf_w_en, w_addr, rf_w_data, inst_pc};
  assign mem.MEM_to_BY_bus   = {w_addr, rf_w_data, sel_valid, mem_valid, rf_w_en};
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector bench for mem_stage at LOAD_WAIT 0, 2 and 3
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if i0 ();
  mem_stage_if i2 ();
  mem_stage_if i3 ();

  mem_stage #(.LOAD_WAIT(0)) dut0 (.clk(clk), .reset(reset), .mem(i0));
  mem_stage #(.LOAD_WAIT(2)) dut2 (.clk(clk), .reset(reset), .mem(i2));
  mem_stage #(.LOAD_WAIT(3)) dut3 (.clk(clk), .reset(reset), .mem(i3));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sel;
    logic [1:0]  wd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [79:0] mk_bus(logic [2:0] stg, logic en, logic sel, logic [1:0] wd,
                                         logic [4:0] waddr, logic [31:0] alu, logic [31:0] pc);
    return {stg, en, sel, wd, 4'hf, waddr, alu, pc};
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b00, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
    vecs[1] = '{1'b1, 2'b01, 32'h00000102, 32'h00A50000, 32'hFFFFFFA5};
    vecs[2] = '{1'b1, 2'b10, 32'h00000102, 32'h00A50000, 32'h000000A5};
    vecs[3] = '{1'b1, 2'b00, 32'h00000100, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[4] = '{1'b1, 2'b11, 32'h00000100, 32'h01020304, 32'h01020304};
    vecs[5] = '{1'b1, 2'b01, 32'h00000200, 32'h0000007F, 32'h0000007F};
    vecs[6] = '{1'b1, 2'b01, 32'h00000203, 32'h80000000, 32'hFFFFFF80};
    vecs[7] = '{1'b1, 2'b10, 32'h00000201, 32'h0000FF00, 32'h000000FF};
    vecs[8] = '{1'b1, 2'b10, 32'h00000203, 32'h80000000, 32'h00000080};

    i0.EXE_to_MEM_bus = '0; i0.EXE_to_MEM_valid = 1'b0; i0.data_ram_r_data = '0; i0.WB_allow_in = 1'b1;
    i2.EXE_to_MEM_bus = '0; i2.EXE_to_MEM_valid = 1'b0; i2.data_ram_r_data = '0; i2.WB_allow_in = 1'b1;
    i3.EXE_to_MEM_bus = '0; i3.EXE_to_MEM_valid = 1'b0; i3.data_ram_r_data = '0; i3.WB_allow_in = 1'b1;

    // reset state
    step(); step();
    smp();
    chk("rst_wb_valid0", 80'(i0.MEM_to_WB_valid), 80'd0);
    chk("rst_allow_in0", 80'(i0.MEM_allow_in), 80'd1);
    chk("rst_by_bus0", 80'(i0.MEM_to_BY_bus), 80'd0);
    chk("rst_wb_valid2", 80'(i2.MEM_to_WB_valid), 80'd0);
    chk("rst_by_bus3", 80'(i3.MEM_to_BY_bus), 80'd0);
    step();
    reset = 1'b0;

    // single-cycle table, LOAD_WAIT = 0
    for (int i = 0; i < 9; i++) begin
      i0.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, vecs[i].sel, vecs[i].wd, 5'd3, vecs[i].alu, 32'h1000 + 32'(i * 4));
      i0.EXE_to_MEM_valid = 1'b1;
      i0.WB_allow_in = 1'b1;
      step();
      i0.EXE_to_MEM_valid = 1'b0;
      i0.data_ram_r_data = vecs[i].rdata;
      smp();
      chk($sformatf("vec%0d_valid", i), 80'(i0.MEM_to_WB_valid), 80'd1);
      chk($sformatf("vec%0d_rf_w_data", i), 80'(i0.MEM_to_WB_bus[63:32]), 80'(vecs[i].exp));
      step();
    end
    smp();
    chk("empty_valid", 80'(i0.MEM_to_WB_valid), 80'd0);
    chk("empty_bus_hold_pc", 80'(i0.MEM_to_WB_bus[31:0]), 80'h1020);
    step();

    // full bus and bypass contents for an ALU op
    i0.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b0, 2'b00, 5'd5, 32'h12345678, 32'h00400010);
    i0.EXE_to_MEM_valid = 1'b1;
    step();
    i0.EXE_to_MEM_valid = 1'b0;
    smp();
    chk("alu_wb_bus", 80'(i0.MEM_to_WB_bus), 80'({1'b1, 5'd5, 32'h12345678, 32'h00400010}));
    chk("alu_by_bus", 80'(i0.MEM_to_BY_bus), 80'({5'd5, 32'h12345678, 3'b111}));
    step();

    // word load held by a 3-cycle write-back stall, LOAD_WAIT = 0
    begin
      int handoffs = 0;
      i0.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 2'b00, 5'd7, 32'h00000040, 32'h00400020);
      i0.EXE_to_MEM_valid = 1'b1;
      step();
      i0.EXE_to_MEM_valid = 1'b0;
      i0.WB_allow_in = 1'b0;
      i0.data_ram_r_data = 32'hDEADBEEF;
      smp();
      chk("stall_allow_in", 80'(i0.MEM_allow_in), 80'd0);
      chk("stall_c0_data", 80'(i0.MEM_to_WB_bus[63:32]), 80'hDEADBEEF);
      handoffs += int'(i0.MEM_to_WB_valid & i0.WB_allow_in);
      for (int c = 1; c < 3; c++) begin
        step();
        i0.data_ram_r_data = 32'h0;
        smp();
        chk($sformatf("stall_c%0d_data", c), 80'(i0.MEM_to_WB_bus[63:32]), 80'hDEADBEEF);
        handoffs += int'(i0.MEM_to_WB_valid & i0.WB_allow_in);
      end
      step();
      i0.WB_allow_in = 1'b1;
      smp();
      chk("stall_release_valid", 80'(i0.MEM_to_WB_valid), 80'd1);
      chk("stall_release_data", 80'(i0.MEM_to_WB_bus[63:32]), 80'hDEADBEEF);
      handoffs += int'(i0.MEM_to_WB_valid & i0.WB_allow_in);
      step();
      smp();
      handoffs += int'(i0.MEM_to_WB_valid & i0.WB_allow_in);
      chk("stall_handoffs", 80'(handoffs), 80'd1);
      step();
    end

    // LOAD_WAIT = 2: wait cycles, exact sample cycle, then load -> ALU -> load with no bubble
    i2.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 2'b00, 5'd9, 32'h00000080, 32'h00400030);
    i2.EXE_to_MEM_valid = 1'b1;
    step();
    i2.EXE_to_MEM_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      i2.data_ram_r_data = 32'h11111111 * 32'(c + 1);
      smp();
      chk($sformatf("lw2_wait%0d_valid", c), 80'(i2.MEM_to_WB_valid), 80'd0);
      chk($sformatf("lw2_wait%0d_allow", c), 80'(i2.MEM_allow_in), 80'd0);
      step();
    end
    i2.data_ram_r_data = 32'h55AA55AA;
    i2.WB_allow_in = 1'b0;
    smp();
    chk("lw2_sample_valid", 80'(i2.MEM_to_WB_valid), 80'd1);
    chk("lw2_sample_by_valid", 80'(i2.MEM_to_BY_bus[2]), 80'd1);
    step();
    i2.data_ram_r_data = 32'h0;
    i2.WB_allow_in = 1'b1;
    i2.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b0, 2'b00, 5'd10, 32'h0000BEEF, 32'h00400034);
    i2.EXE_to_MEM_valid = 1'b1;
    smp();
    chk("lw2_held_data", 80'(i2.MEM_to_WB_bus[63:32]), 80'h55AA55AA);
    chk("lw2_leave_allow", 80'(i2.MEM_allow_in), 80'd1);
    step();
    i2.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 2'b10, 5'd11, 32'h00000100, 32'h00400038);
    smp();
    chk("b2b_alu_valid", 80'(i2.MEM_to_WB_valid), 80'd1);
    chk("b2b_alu_data", 80'(i2.MEM_to_WB_bus[63:32]), 80'h0000BEEF);
    step();
    i2.EXE_to_MEM_valid = 1'b0;
    i2.data_ram_r_data = 32'hAAAAAAAA;
    smp();
    chk("b2b_load_restart0", 80'(i2.MEM_to_WB_valid), 80'd0);
    step();
    smp();
    chk("b2b_load_restart1", 80'(i2.MEM_to_WB_valid), 80'd0);
    step();
    i2.data_ram_r_data = 32'h00000077;
    smp();
    chk("b2b_load_valid", 80'(i2.MEM_to_WB_valid), 80'd1);
    chk("b2b_load_data", 80'(i2.MEM_to_WB_bus[63:32]), 80'h00000077);
    step();

    // LOAD_WAIT = 3: reset at wait cycle 1 drops the load, next load samples fresh data
    i3.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 2'b00, 5'd12, 32'h00000200, 32'h00400040);
    i3.EXE_to_MEM_valid = 1'b1;
    step();
    i3.EXE_to_MEM_valid = 1'b0;
    i3.data_ram_r_data = 32'hBAD0BAD0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    smp();
    chk("rst_mid_wb_valid", 80'(i3.MEM_to_WB_valid), 80'd0);
    chk("rst_mid_allow", 80'(i3.MEM_allow_in), 80'd1);
    chk("rst_mid_by_valid", 80'(i3.MEM_to_BY_bus[2:0]), 80'd0);
    step();
    i3.EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 2'b00, 5'd13, 32'h00000204, 32'h00400044);
    i3.EXE_to_MEM_valid = 1'b1;
    step();
    i3.EXE_to_MEM_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk($sformatf("lw3_wait%0d_valid", c), 80'(i3.MEM_to_WB_valid), 80'd0);
      step();
    end
    i3.data_ram_r_data = 32'h600DF00D;
    smp();
    chk("lw3_sample_valid", 80'(i3.MEM_to_WB_valid), 80'd1);
    chk("lw3_sample_data", 80'(i3.MEM_to_WB_bus[63:32]), 80'h600DF00D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
